// File: rtl/mmul_sched_if.sv
// mmul_sched_if: bundles the two requester ports, the mmul core drive/return and the response port.
// Latency: none; it only groups wires.
// Backpressure: it carries req*_valid/req*_ready and rsp_valid/rsp_ready between the two sides.
// Ports (all signals): req0_/req1_ valid, ready, mat_a, mat_b; mm_ enable, mat_a, mat_b, mat_axb, done, invalid;
//   rsp_ valid, ready, id, mat, invalid, timeout. master = scheduler side, slave = requesters/core/consumer side.
interface mmul_sched_if #(
  parameter int WIDTH = 8,
  parameter int DIM   = 3
);
  localparam int MW = DIM * DIM * WIDTH;

  logic          req0_valid;
  logic          req0_ready;
  logic [MW-1:0] req0_mat_a;
  logic [MW-1:0] req0_mat_b;
  logic          req1_valid;
  logic          req1_ready;
  logic [MW-1:0] req1_mat_a;
  logic [MW-1:0] req1_mat_b;
  logic          mm_enable;
  logic [MW-1:0] mm_mat_a;
  logic [MW-1:0] mm_mat_b;
  logic [MW-1:0] mm_mat_axb;
  logic          mm_done;
  logic          mm_invalid;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [MW-1:0] rsp_mat;
  logic          rsp_invalid;
  logic          rsp_timeout;

  modport master (
    input  req0_valid, req0_mat_a, req0_mat_b,
    input  req1_valid, req1_mat_a, req1_mat_b,
    input  mm_mat_axb, mm_done, mm_invalid, rsp_ready,
    output req0_ready, req1_ready,
    output mm_enable, mm_mat_a, mm_mat_b,
    output rsp_valid, rsp_id, rsp_mat, rsp_invalid, rsp_timeout
  );

  modport slave (
    output req0_valid, req0_mat_a, req0_mat_b,
    output req1_valid, req1_mat_a, req1_mat_b,
    output mm_mat_axb, mm_done, mm_invalid, rsp_ready,
    input  req0_ready, req1_ready,
    input  mm_enable, mm_mat_a, mm_mat_b,
    input  rsp_valid, rsp_id, rsp_mat, rsp_invalid, rsp_timeout
  );
endinterface

// File: rtl/mmul_sched.sv
// mmul_sched: round-robin scheduler of two requesters onto one shared mmul core.
// Latency: grant in IDLE, mm_enable the next cycle, rsp_valid the cycle after mm_done is sampled.
// Backpressure: response held in RESP until rsp_ready; no requester is granted while a job is in flight.
// Ports: clk; reset (asynchronous, active-high); bus (mmul_sched_if.master) with the req0/req1
//   operand ports, the mm_* core drive/return signals and the tagged rsp_* response port.
// Option: define MMUL_SCHED_TIMEOUT_EN to abort a RUN that lasts TIMEOUT cycles without mm_done.
module mmul_sched #(
  parameter int WIDTH   = 8,
  parameter int DIM     = 3,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  mmul_sched_if.master bus
);
  localparam int MW = DIM * DIM * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t        state_q, state_d;
  logic          rr_q;
  logic [MW-1:0] mat_a_q, mat_b_q, rsp_mat_q;
  logic          rsp_id_q, rsp_inv_q, rsp_to_q;
  logic          gnt0, gnt1, grant, done_run, to_hit;

  // Grants are decoded only in IDLE; rr_q breaks ties when both are valid.
  always_comb begin
    state_d  = state_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    done_run = 1'b0;
    case (state_q)
      IDLE: begin
        gnt0 = bus.req0_valid && (!bus.req1_valid || !rr_q);
        gnt1 = bus.req1_valid && (!bus.req0_valid || rr_q);
        if (gnt0 || gnt1) state_d = RUN;
      end
      RUN: begin
        done_run = bus.mm_done;
        if (bus.mm_done || to_hit) state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant = gnt0 || gnt1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      mat_a_q   <= '0;
      mat_b_q   <= '0;
      rsp_mat_q <= '0;
      rsp_id_q  <= 1'b0;
      rsp_inv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        mat_a_q  <= gnt1 ? bus.req1_mat_a : bus.req0_mat_a;
        mat_b_q  <= gnt1 ? bus.req1_mat_b : bus.req0_mat_b;
        rsp_id_q <= gnt1;
        rr_q     <= !gnt1;           // the other requester wins the next tie
      end
      if (done_run) begin
        rsp_mat_q <= bus.mm_mat_axb;
        rsp_inv_q <= bus.mm_invalid;
      end else if (to_hit) begin
        rsp_mat_q <= '0;             // aborted job: no product, flagged invalid
        rsp_inv_q <= 1'b1;
      end
    end
  end

`ifdef MMUL_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] run_cnt_q;

  // mm_done in the same cycle as the limit takes priority over the abort.
  assign to_hit = (state_q == RUN) && !bus.mm_done && (run_cnt_q == CW'(TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_cnt_q <= '0;
      rsp_to_q  <= 1'b0;
    end else begin
      if (grant) begin
        run_cnt_q <= '0;
        rsp_to_q  <= 1'b0;
      end else if (state_q == RUN) begin
        run_cnt_q <= run_cnt_q + CW'(1);   // leaves RUN at TIMEOUT, so no wrap
      end
      if (to_hit) rsp_to_q <= 1'b1;
    end
  end
`else
  // Without the watchdog RUN waits for mm_done indefinitely and TIMEOUT has no effect.
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign to_hit         = 1'b0;
  assign rsp_to_q       = 1'b0;
`endif

  // Ready is masked by reset so it reads 0 while reset is held, even with valid high.
  assign bus.req0_ready  = gnt0 && !reset;
  assign bus.req1_ready  = gnt1 && !reset;
  assign bus.mm_enable   = (state_q == RUN);
  assign bus.mm_mat_a    = mat_a_q;
  assign bus.mm_mat_b    = mat_b_q;
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_mat     = rsp_mat_q;
  assign bus.rsp_invalid = rsp_inv_q;
  assign bus.rsp_timeout = rsp_to_q;
endmodule

// File: tb/tb_mmul_sched.sv
// tb_mmul_sched: randomized and directed bench for mmul_sched against a transaction-level model.
// Latency: checks grant, enable and response timing cycle by cycle at the falling edge.
// Backpressure: exercises rsp_ready stalls, dropped requests and contention.
module tb_mmul_sched;
  localparam int WIDTH = 8;
  localparam int DIM   = 3;
  localparam int MW    = DIM * DIM * WIDTH;
  localparam int TMO   = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mmul_sched_if #(.WIDTH(WIDTH), .DIM(DIM)) bus ();

  mmul_sched #(.WIDTH(WIDTH), .DIM(DIM), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] mm(input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [MW-1:0]    r;
    logic [WIDTH-1:0] s;
    r = '0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        s = '0;
        for (int k = 0; k < DIM; k++)
          s = s + a[(i*DIM+k)*WIDTH +: WIDTH] * b[(k*DIM+j)*WIDTH +: WIDTH];
        r[(i*DIM+j)*WIDTH +: WIDTH] = s;
      end
    return r;
  endfunction

  function automatic logic [MW-1:0] rnd_mat();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[MW-1:0];
  endfunction

  // ---------------- core model ----------------
  int  core_cnt = 0;
  int  cur_lat  = 3;
  int  lat_fix  = 3;
  bit  lat_rand = 1'b0;
  bit  hang     = 1'b0;
  bit  spurious = 1'b0;
  int  inv_mode = 0;       // 0 never, 1 always, 2 random

  initial begin
    bus.mm_done    = 1'b0;
    bus.mm_invalid = 1'b0;
    bus.mm_mat_axb = '0;
    forever begin
      @(posedge clk); #1;
      if (!bus.mm_enable) begin
        core_cnt       = 0;
        cur_lat        = lat_rand ? int'($urandom_range(1, 6)) : lat_fix;
        bus.mm_done    = spurious && ($urandom_range(0, 2) == 0);
        bus.mm_invalid = 1'($urandom_range(0, 1));
        bus.mm_mat_axb = rnd_mat();
      end else begin
        core_cnt++;
        bus.mm_done = !hang && (core_cnt == cur_lat);
        if (core_cnt == cur_lat) begin
          bus.mm_mat_axb = mm(bus.mm_mat_a, bus.mm_mat_b);
          bus.mm_invalid = (inv_mode == 1) || (inv_mode == 2 && $urandom_range(0, 1) == 1);
        end
      end
    end
  end

  // ---------------- reference model + per-cycle checks ----------------
  // m_phase: 0 waiting for a request, 1 job with the core, 2 response offered.
  int            m_phase = 0;
  bit            m_rr = 0, m_id = 0, m_inv = 0, m_to = 0;
  logic [MW-1:0] m_a = '0, m_b = '0, m_mat = '0;
  int            m_run = 0;
  int            gnt_log[$];
  bit            hs0 = 0, hs1 = 0;

  always @(negedge clk) begin
    bit e0, e1;
    if (reset) begin
      m_phase = 0; m_rr = 0; m_id = 0; m_inv = 0; m_to = 0;
      m_a = '0; m_b = '0; m_mat = '0;
    end
    e0 = !reset && m_phase == 0 && bus.req0_valid && (!bus.req1_valid || !m_rr);
    e1 = !reset && m_phase == 0 && bus.req1_valid && (!bus.req0_valid || m_rr);
    chk("req0_ready",  MW'(bus.req0_ready),  MW'(e0));
    chk("req1_ready",  MW'(bus.req1_ready),  MW'(e1));
    chk("mm_enable",   MW'(bus.mm_enable),   MW'(!reset && m_phase == 1));
    chk("rsp_valid",   MW'(bus.rsp_valid),   MW'(!reset && m_phase == 2));
    chk("mm_mat_a",    bus.mm_mat_a,         m_a);
    chk("mm_mat_b",    bus.mm_mat_b,         m_b);
    chk("rsp_id",      MW'(bus.rsp_id),      MW'(m_id));
    chk("rsp_mat",     bus.rsp_mat,          m_mat);
    chk("rsp_invalid", MW'(bus.rsp_invalid), MW'(m_inv));
    chk("rsp_timeout", MW'(bus.rsp_timeout), MW'(m_to));
    hs0 = bus.req0_valid && bus.req0_ready;
    hs1 = bus.req1_valid && bus.req1_ready;
    if (hs0) gnt_log.push_back(0);
    if (hs1) gnt_log.push_back(1);
    if (!reset) begin
      case (m_phase)
        0: if (e0 || e1) begin
          m_id    = e1;
          m_a     = e1 ? bus.req1_mat_a : bus.req0_mat_a;
          m_b     = e1 ? bus.req1_mat_b : bus.req0_mat_b;
          m_rr    = !e1;
          m_to    = 0;
          m_run   = 0;
          m_phase = 1;
        end
        1: begin
          m_run++;
          if (bus.mm_done) begin
            m_mat   = mm(m_a, m_b);
            m_inv   = bus.mm_invalid;
            m_phase = 2;
          end
`ifdef MMUL_SCHED_TIMEOUT_EN
          else if (m_run == TMO + 1) begin
            m_mat   = '0;
            m_inv   = 1;
            m_to    = 1;
            m_phase = 2;
          end
`endif
        end
        2: if (bus.rsp_ready) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input bit id, input logic [MW-1:0] a, input logic [MW-1:0] b, input string tag);
    int n = 0;
    if (id) begin bus.req1_mat_a = a; bus.req1_mat_b = b; bus.req1_valid = 1'b1; end
    else    begin bus.req0_mat_a = a; bus.req0_mat_b = b; bus.req0_valid = 1'b1; end
    while (n < 100) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) break;
      n++;
    end
    chk({tag, "_grant"}, MW'(id ? bus.req1_ready : bus.req0_ready), MW'(1));
    @(posedge clk); #1;
    if (id) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!bus.rsp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_rsp_valid"}, MW'(bus.rsp_valid), MW'(1));
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  logic [MW-1:0] ident, seq, ta, tb_;
  int            n;

  initial begin
    bus.req0_valid = 0; bus.req0_mat_a = '0; bus.req0_mat_b = '0;
    bus.req1_valid = 0; bus.req1_mat_a = '0; bus.req1_mat_b = '0;
    bus.rsp_ready  = 0;
    ident = '0;
    seq   = '0;
    for (int i = 0; i < DIM; i++) ident[(i*DIM+i)*WIDTH +: WIDTH] = 8'd1;
    for (int k = 0; k < DIM*DIM; k++) seq[k*WIDTH +: WIDTH] = WIDTH'(k + 1);

    #1;
    chk("rst_mm_enable", MW'(bus.mm_enable), MW'(0));
    chk("rst_rsp_valid", MW'(bus.rsp_valid), MW'(0));
    chk("rst_rsp_mat",   bus.rsp_mat,        MW'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // single job: identity x {1..9}
    send(0, ident, seq, "single");
    wait_rsp("single");
    chk("single_id",  MW'(bus.rsp_id),      MW'(0));
    chk("single_mat", bus.rsp_mat,          seq);
    chk("single_inv", MW'(bus.rsp_invalid), MW'(0));
    bus.rsp_ready = 1;
    @(posedge clk); #1;
    chk("single_done", MW'(bus.rsp_valid), MW'(0));

    // contention from a fresh reset: grants alternate 0,1,0,1
    do_reset();
    gnt_log.delete();
    bus.req0_mat_a = rnd_mat(); bus.req0_mat_b = rnd_mat();
    bus.req1_mat_a = rnd_mat(); bus.req1_mat_b = rnd_mat();
    bus.req0_valid = 1; bus.req1_valid = 1;
    n = 0;
    while (gnt_log.size() < 4 && n < 200) begin @(posedge clk); #1; n++; end
    bus.req0_valid = 0; bus.req1_valid = 0;
    chk("cont_count", MW'(gnt_log.size()), MW'(4));
    for (int i = 0; i < 4; i++)
      chk("cont_order", MW'(gnt_log.size() > i ? gnt_log[i] : 9), MW'(i % 2));
    repeat (20) @(posedge clk);

    // backpressure: response held for 10 cycles while req1 waits
    #1 bus.rsp_ready = 0;
    ta = rnd_mat(); tb_ = rnd_mat();
    send(0, ta, tb_, "bp");
    bus.req1_mat_a = rnd_mat(); bus.req1_mat_b = rnd_mat(); bus.req1_valid = 1;
    wait_rsp("bp");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid",  MW'(bus.rsp_valid),  MW'(1));
      chk("bp_mat",    bus.rsp_mat,         mm(ta, tb_));
      chk("bp_id",     MW'(bus.rsp_id),     MW'(0));
      chk("bp_enable", MW'(bus.mm_enable),  MW'(0));
      chk("bp_nogrant",MW'(bus.req1_ready), MW'(0));
    end
    bus.rsp_ready = 1;
    @(posedge clk); #1;
    chk("bp_release_valid", MW'(bus.rsp_valid),  MW'(0));
    chk("bp_release_grant", MW'(bus.req1_ready), MW'(1));
    @(posedge clk); #1;
    bus.req1_valid = 0;
    repeat (12) @(posedge clk);

    // invalid flag carried for one job only
    #1 bus.rsp_ready = 0;
    inv_mode = 1;
    send(1, rnd_mat(), rnd_mat(), "inv1");
    wait_rsp("inv1");
    chk("inv1_flag", MW'(bus.rsp_invalid), MW'(1));
    inv_mode = 0;
    bus.rsp_ready = 1;
    @(posedge clk); #1;
    send(0, rnd_mat(), rnd_mat(), "inv0");
    wait_rsp("inv0");
    chk("inv0_flag", MW'(bus.rsp_invalid), MW'(0));
    repeat (4) @(posedge clk);

    // reset three cycles into a job
    #1 lat_fix = 6;
    send(0, rnd_mat(), rnd_mat(), "rst_run");
    bus.req0_valid = 1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rr_mm_enable", MW'(bus.mm_enable),   MW'(0));
    chk("rr_ready0",    MW'(bus.req0_ready),  MW'(0));
    chk("rr_rsp_valid", MW'(bus.rsp_valid),   MW'(0));
    chk("rr_rsp_id",    MW'(bus.rsp_id),      MW'(0));
    chk("rr_rsp_inv",   MW'(bus.rsp_invalid), MW'(0));
    chk("rr_rsp_to",    MW'(bus.rsp_timeout), MW'(0));
    chk("rr_mm_a",      bus.mm_mat_a,         MW'(0));
    chk("rr_mm_b",      bus.mm_mat_b,         MW'(0));
    chk("rr_rsp_mat",   bus.rsp_mat,          MW'(0));
    bus.req0_valid = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      chk("rr_no_stale", MW'(bus.rsp_valid), MW'(0));
    end
    lat_fix = 3;
    gnt_log.delete();
    bus.req0_valid = 1; bus.req1_valid = 1;
    n = 0;
    while (gnt_log.size() < 2 && n < 100) begin @(posedge clk); #1; n++; end
    bus.req0_valid = 0; bus.req1_valid = 0;
    chk("rr_first",  MW'(gnt_log.size() > 0 ? gnt_log[0] : 9), MW'(0));
    chk("rr_second", MW'(gnt_log.size() > 1 ? gnt_log[1] : 9), MW'(1));
    repeat (12) @(posedge clk);

`ifdef MMUL_SCHED_TIMEOUT_EN
    // watchdog: the core never finishes
    #1 bus.rsp_ready = 0;
    hang = 1;
    send(0, rnd_mat(), rnd_mat(), "to");
    n = 0;
    while (!bus.rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("to_latency", MW'(n), MW'(9));
    chk("to_flag",    MW'(bus.rsp_timeout), MW'(1));
    chk("to_inv",     MW'(bus.rsp_invalid), MW'(1));
    chk("to_mat",     bus.rsp_mat,          MW'(0));
    hang = 0;
    bus.rsp_ready = 1;
    send(1, rnd_mat(), rnd_mat(), "to_next");
    chk("to_clear", MW'(bus.rsp_timeout), MW'(0));
    wait_rsp("to_next");
    repeat (4) @(posedge clk);
`endif

    // randomized traffic
    lat_rand = 1; spurious = 1; inv_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!bus.req0_valid || hs0) begin
        bus.req0_valid = ($urandom_range(0, 1) == 1);
        bus.req0_mat_a = rnd_mat(); bus.req0_mat_b = rnd_mat();
      end else if ($urandom_range(0, 7) == 0) begin
        bus.req0_valid = 0;
      end
      if (!bus.req1_valid || hs1) begin
        bus.req1_valid = ($urandom_range(0, 1) == 1);
        bus.req1_mat_a = rnd_mat(); bus.req1_mat_b = rnd_mat();
      end else if ($urandom_range(0, 7) == 0) begin
        bus.req1_valid = 0;
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 1;
    repeat (30) @(posedge clk);
    #1;
    chk("drain_valid",  MW'(bus.rsp_valid), MW'(0));
    chk("drain_enable", MW'(bus.mm_enable), MW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
